// File: rtl/fifo_burst_writer_if.sv
// Stream and FIFO write-port bundle for fifo_burst_writer.
// Latency: none, wires only.
// Backpressure: s_ready toward upstream; full/prog_full from the FIFO.
// Ports: s_data/s_valid/s_last/s_ready upstream stream; din/wr_en FIFO write;
//        full/prog_full/wr_ack/overflow FIFO status and write response.
interface fifo_burst_writer_if #(
   parameter int data_width = 8
);
   logic [data_width-1:0] s_data;
   logic                  s_valid;
   logic                  s_last;
   logic                  s_ready;
   logic [data_width-1:0] din;
   logic                  wr_en;
   logic                  full;
   logic                  prog_full;
   logic                  wr_ack;
   logic                  overflow;

   // master: the burst writer (consumes the stream, drives the FIFO write port)
   modport master (
      input  s_data, s_valid, s_last,
      output s_ready,
      output din, wr_en,
      input  full, prog_full, wr_ack, overflow
   );

   // slave: the surroundings (upstream source plus the FIFO)
   modport slave (
      output s_data, s_valid, s_last,
      input  s_ready,
      input  din, wr_en,
      output full, prog_full, wr_ack, overflow
   );
endinterface

// File: rtl/fifo_burst_writer.sv
// Burst-gated producer for the write port of the dual-clock FIFO, with ack checking and stats.
// Latency: handshake -> wr_en 1 cycle; wr_en -> wr_ack/overflow checked 1 cycle later.
// Backpressure: s_ready only in BURST with full low and beats left; bursts start only with prog_full low.
// Ports: clk_wr, rst (sync, active-low); enable gates new bursts; bus = stream + FIFO write port;
//        busy, burst_done, wr_count, drop_count, err/err_clr status.
module fifo_burst_writer #(
   parameter int data_width    = 8,
   parameter int burst_len     = 16,
   parameter int settle_cycles = 3,
   parameter int cnt_width     = 32
) (
   input  logic                 clk_wr,
   input  logic                 rst,
   input  logic                 enable,
   fifo_burst_writer_if.master  bus,
   output logic                 busy,
   output logic                 burst_done,
   output logic [cnt_width-1:0] wr_count,
   output logic [15:0]          drop_count,
   output logic                 err,
   input  logic                 err_clr
);

   typedef enum logic [1:0] {IDLE, BURST, SETTLE} state_t;

   // burst_len is at most 255 and settle_cycles at most 15
   localparam logic [7:0] BEATS_INIT  = 8'(burst_len);
   localparam logic [3:0] SETTLE_INIT = 4'(settle_cycles - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] beats_left;
   logic [3:0] settle_left;
   logic       hs;
   logic       burst_end;
   logic       burst_start;
   logic       ack_exp;
   logic       err_set;

   always_ff @(posedge clk_wr) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.s_ready = 1'b0;
      hs          = 1'b0;
      burst_end   = 1'b0;
      burst_start = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !bus.prog_full && bus.s_valid) begin
               burst_start = 1'b1;
               state_nxt   = BURST;
            end
         end
         BURST: begin
            // full stalls the burst without ending it
            bus.s_ready = !bus.full && (beats_left != 8'd0);
            hs          = bus.s_valid && bus.s_ready;
            // last beat and s_last together still give one exit
            burst_end   = hs && ((beats_left == 8'd1) || bus.s_last);
            if (burst_end) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (settle_left == 4'd0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk_wr) begin
      if (!rst) begin
         bus.din     <= '0;
         bus.wr_en   <= 1'b0;
         burst_done  <= 1'b0;
         beats_left  <= 8'd0;
         settle_left <= 4'd0;
         ack_exp     <= 1'b0;
      end else begin
         bus.wr_en  <= hs;
         if (hs) bus.din <= bus.s_data;
         burst_done <= burst_end;
         ack_exp    <= bus.wr_en;

         if (burst_start)  beats_left <= BEATS_INIT;
         else if (hs)      beats_left <= beats_left - 8'd1;

         // loaded so that SETTLE lasts exactly settle_cycles cycles
         if (burst_end)                                  settle_left <= SETTLE_INIT;
         else if (state == SETTLE && settle_left != 4'd0) settle_left <= settle_left - 4'd1;
      end
   end

   // Every write must get exactly one of wr_ack/overflow, nothing may answer a
   // non-write, and any overflow means the prog_full gating failed.
   assign err_set = (ack_exp && (bus.wr_ack == bus.overflow)) ||
                    (!ack_exp && (bus.wr_ack || bus.overflow)) ||
                    bus.overflow;

   always_ff @(posedge clk_wr) begin
      if (!rst) begin
         wr_count   <= '0;
         drop_count <= 16'd0;
         err        <= 1'b0;
      end else begin
         if (bus.wr_ack) wr_count <= wr_count + cnt_width'(1);
         if (bus.overflow && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         // a new error in the clearing cycle keeps err set
         err <= err_set || (err && !err_clr);
      end
   end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Bench for fifo_burst_writer: stream driver, FIFO response model, in-order scoreboard on din.
// Latency: writes expected one cycle after each handshake, responses one cycle after wr_en.
// Backpressure: full and prog_full driven by the bench to exercise stalls and gating.
module tb_fifo_burst_writer;

   logic        clk_wr;
   logic        rst;
   logic        enable;
   logic        busy;
   logic        burst_done;
   logic [31:0] wr_count;
   logic [15:0] drop_count;
   logic        err;
   logic        err_clr;

   fifo_burst_writer_if #(.data_width(8)) bus ();

   fifo_burst_writer #(
      .data_width(8), .burst_len(16), .settle_cycles(3), .cnt_width(32)
   ) dut (
      .clk_wr(clk_wr), .rst(rst), .enable(enable), .bus(bus),
      .busy(busy), .burst_done(burst_done), .wr_count(wr_count),
      .drop_count(drop_count), .err(err), .err_clr(err_clr)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   initial begin
      clk_wr = 1'b0;
      forever #5 clk_wr = ~clk_wr;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // FIFO model: answers each write one cycle later; write number ovf_target
   // gets overflow instead of wr_ack. spur_ack injects an unsolicited ack.
   int model_wn   = 0;
   int ovf_target = 0;
   bit spur_ack   = 1'b0;

   initial begin
      bit p;
      bit pf;
      bus.wr_ack   = 1'b0;
      bus.overflow = 1'b0;
      forever begin
         @(negedge clk_wr);
         p = (bus.wr_en === 1'b1);
         if (p) model_wn++;
         pf = p && (model_wn == ovf_target);
         @(posedge clk_wr);
         #1;
         bus.wr_ack   = (p && !pf) || spur_ack;
         bus.overflow = pf;
      end
   end

   // Scoreboard and burst bookkeeping
   logic [7:0] exp_q[$];
   int cyc    = 0;
   int writes = 0;
   int bd_cnt = 0;
   int bd_cyc[8];
   int wr_at_bd[8];
   int first_wr_after[8];

   initial for (int i = 0; i < 8; i++) first_wr_after[i] = -1;

   always @(negedge clk_wr) begin
      logic [7:0] e;
      cyc++;
      if (bus.wr_en === 1'b1) begin
         writes++;
         chk("sb_has_entry", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("din", bus.din, e);
         end
         if (bd_cnt > 0 && bd_cnt <= 8 && first_wr_after[bd_cnt-1] < 0)
            first_wr_after[bd_cnt-1] = cyc;
      end
      if (burst_done === 1'b1) begin
         if (bd_cnt < 8) begin
            bd_cyc[bd_cnt]   = cyc;
            wr_at_bd[bd_cnt] = writes;
         end
         bd_cnt++;
      end
      if (rst === 1'b1 && bus.s_valid === 1'b1 && bus.s_ready === 1'b1)
         exp_q.push_back(bus.s_data);
   end

   // Presents n words base, base+1, ...; s_last on word last_idx (-1 for none).
   task automatic drive(input int n, input int last_idx, input logic [7:0] base);
      int idx    = 0;
      int budget = 0;
      bit acc;
      while (idx < n) begin
         bus.s_valid = 1'b1;
         bus.s_data  = base + idx[7:0];
         bus.s_last  = (idx == last_idx);
         @(negedge clk_wr);
         acc = (bus.s_ready === 1'b1);
         @(posedge clk_wr);
         #2;
         if (acc) idx++;
         budget++;
         if (budget > 300) begin
            chk("drive_timeout", idx, n);
            break;
         end
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_wr);
      #2;
   endtask

   initial begin
      rst           = 1'b0;
      enable        = 1'b1;
      err_clr       = 1'b0;
      bus.s_valid   = 1'b1;
      bus.s_data    = 8'h55;
      bus.s_last    = 1'b0;
      bus.full      = 1'b0;
      bus.prog_full = 1'b0;

      // reset with s_valid held high
      idle(2);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_din", bus.din, 0);
      chk("rst_burst_done", burst_done, 0);
      bus.s_valid = 1'b0;
      rst = 1'b1;
      idle(2);

      // full 16-word burst followed immediately by a 5-word burst ended by s_last
      drive(16, -1, 8'h00);
      drive(5, 4, 8'h40);
      idle(12);
      chk("ab_burst_done_cnt", bd_cnt, 2);
      chk("a_writes", wr_at_bd[0], 16);
      chk("b_writes", wr_at_bd[1], 21);
      chk("settle_gap", first_wr_after[0] - bd_cyc[0], 5);
      chk("ab_wr_count", wr_count, 21);
      chk("ab_busy", busy, 0);
      chk("ab_err", err, 0);

      // backpressure: full for 4 cycles in the middle of a 10-word burst
      fork
         drive(10, 9, 8'h80);
         begin
            int w0 = writes;
            int t  = 0;
            while (writes < w0 + 4 && t < 100) begin
               @(posedge clk_wr);
               #2;
               t++;
            end
            chk("stall_reached", writes >= w0 + 4, 1);
            bus.full = 1'b1;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk_wr);
               chk("stall_s_ready", bus.s_ready, 0);
               if (i > 0) chk("stall_wr_en", bus.wr_en, 0);
               @(posedge clk_wr);
               #2;
            end
            bus.full = 1'b0;
            @(negedge clk_wr);
            chk("stall_tail_wr_en", bus.wr_en, 0);
         end
      join
      idle(12);
      chk("c_burst_done_cnt", bd_cnt, 3);
      chk("c_writes", wr_at_bd[2], 31);
      chk("c_wr_count", wr_count, 31);
      chk("c_drop_count", drop_count, 0);

      // prog_full gating in IDLE
      bus.prog_full = 1'b1;
      bus.s_valid   = 1'b1;
      bus.s_data    = 8'hC0;
      bus.s_last    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         chk("gate_busy", busy, 0);
         chk("gate_wr_en", bus.wr_en, 0);
      end
      bus.prog_full = 1'b0;
      idle(1);
      chk("gate_release_busy", busy, 1);
      drive(3, 2, 8'hC0);
      idle(12);
      chk("d_burst_done_cnt", bd_cnt, 4);
      chk("d_wr_count", wr_count, 34);
      chk("d_err", err, 0);

      // overflow on the 2nd write of a 4-word burst
      ovf_target = model_wn + 2;
      drive(4, 3, 8'hE0);
      idle(12);
      chk("ovf_drop_count", drop_count, 1);
      chk("ovf_err", err, 1);
      chk("ovf_wr_count", wr_count, 37);
      idle(5);
      chk("ovf_err_held", err, 1);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      chk("err_cleared", err, 0);
      chk("err_clr_keeps_drop", drop_count, 1);

      // unsolicited wr_ack
      spur_ack = 1'b1;
      idle(1);
      spur_ack = 1'b0;
      idle(1);
      chk("spur_err", err, 1);
      chk("spur_wr_count", wr_count, 38);

      idle(4);
      chk("final_sb_empty", exp_q.size(), 0);
      chk("final_writes", writes, 38);
      chk("final_burst_done_cnt", bd_cnt, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
